pipe_ctrl: RTL and testbench

- Sequencer for the 3-stage FD/X/MW RV32I pipeline.
- Owns the fetch PC and the per-stage valid bits.
- Applies global stalls and kills wrong-path instructions on X-stage redirects, injecting NOPs into decode.
- Keeps the cycle and instructions-retired counters read by the CSR/MMIO path.
- Sits between the BIOS/IMEM read ports, the control logic and the stage registers.

---
 rtl/pipe_ctrl.sv | 94 +++++++++
 tb/tb_pipe_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Fetch/valid sequencer for the 3-stage FD/X/MW RV32I pipeline: owns the fetch PC,
// stage valid bits, stall/redirect handling and the cycle/instret counters.
`timescale 1ns/1ps
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_req,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic [31:0]      inst_mem,
  input  logic             counter_rst,
  output logic [31:0]      pc_fetch,
  output logic [31:0]      pc_fd,
  output logic [31:0]      inst_fd,
  output logic             fd_valid,
  output logic             x_valid,
  output logic             mw_valid,
  output logic             pipe_en,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] inst_cnt,
  output logic [1:0]       state
);

  localparam logic [1:0] S_RESET = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_STALL = 2'b10;

  logic running;

  assign running = (state != S_RESET);
  assign pipe_en = running & ~stall_req;
  assign inst_fd = fd_valid ? inst_mem : NOP;

  always_comb begin
    pc_fetch = pc_fd + 32'd4;
    if (!running || !pipe_en)
      pc_fetch = running ? pc_fd : RESET_PC;
    else if (redirect)
      pc_fetch = redirect_pc;
    else if (!fd_valid)
      // pc_fd already holds the redirect target but its fetch was killed: refetch it
      pc_fetch = pc_fd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_RUN;
        S_RUN:   state <= stall_req ? S_STALL : S_RUN;
        S_STALL: state <= stall_req ? S_STALL : S_RUN;
        default: state <= S_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_fd    <= RESET_PC;
      fd_valid <= 1'b0;
      x_valid  <= 1'b0;
      mw_valid <= 1'b0;
    end else if (!running) begin
      pc_fd    <= RESET_PC;
      fd_valid <= 1'b1;
    end else if (pipe_en) begin
      pc_fd    <= pc_fetch;
      mw_valid <= x_valid;
      x_valid  <= fd_valid & ~redirect;
      fd_valid <= ~redirect;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else if (counter_rst) begin
      cycle_cnt <= '0;
      inst_cnt  <= '0;
    end else begin
      if (running)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (pipe_en && mw_valid)
        inst_cnt <= inst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, straight-line fetch, redirect, stall+redirect,
// counter clear/wrap and asynchronous mid-stall reset.
`timescale 1ns/1ps
module tb_pipe_ctrl;

  localparam logic [31:0] RPC = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] K   = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst, stall_req, redirect, counter_rst;
  logic [31:0] redirect_pc, inst_mem;
  logic [31:0] pc_fetch, pc_fd, inst_fd, cycle_cnt, inst_cnt;
  logic        fd_valid, x_valid, mw_valid, pipe_en;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_pc, exp_cyc, exp_inst;

  pipe_ctrl #(.RESET_PC(RPC), .NOP(NOP), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_mem(inst_mem), .counter_rst(counter_rst),
    .pc_fetch(pc_fetch), .pc_fd(pc_fd), .inst_fd(inst_fd),
    .fd_valid(fd_valid), .x_valid(x_valid), .mw_valid(mw_valid),
    .pipe_en(pipe_en), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .state(state)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory: content is address xor K
  always @(posedge clk) inst_mem <= pc_fetch ^ K;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; stall_req = 1'b0; redirect = 1'b0; counter_rst = 1'b0;
    redirect_pc = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    // cycle 0: still in RESET
    chk("c0_state",    32'(state), 32'(2'b00));
    chk("c0_pc_fetch", pc_fetch, RPC);
    chk("c0_pc_fd",    pc_fd, RPC);
    chk("c0_valids",   32'({fd_valid, x_valid, mw_valid}), 32'(3'b000));
    chk("c0_pipe_en",  32'(pipe_en), 32'(1'b0));
    chk("c0_inst_fd",  inst_fd, NOP);
    chk("c0_cnts",     cycle_cnt | inst_cnt, 32'h0);

    tick(); // c1
    chk("c1_pc_fd",    pc_fd, RPC);
    chk("c1_valids",   32'({fd_valid, x_valid, mw_valid}), 32'(3'b100));
    chk("c1_pc_fetch", pc_fetch, RPC + 32'd4);
    chk("c1_inst_fd",  inst_fd, RPC ^ K);
    chk("c1_state",    32'(state), 32'(2'b01));
    chk("c1_cycle",    cycle_cnt, 32'd0);
    tick(); // c2
    chk("c2_valids",   32'({fd_valid, x_valid, mw_valid}), 32'(3'b110));
    tick(); // c3
    chk("c3_valids",   32'({fd_valid, x_valid, mw_valid}), 32'(3'b111));
    chk("c3_inst",     inst_cnt, 32'd0);
    tick(); // c4
    chk("c4_inst",     inst_cnt, 32'd1);
    chk("c4_cycle",    cycle_cnt, 32'd3);
    tick(); // c5
    chk("c5_pc_fd",    pc_fd, 32'h4000_0010);

    // Redirect while pc_fd = 4000_0010
    redirect = 1'b1; redirect_pc = 32'h4000_0100;
    #1 chk("rd_pc_fetch", pc_fetch, 32'h4000_0100);
    tick(); // c6: bubble
    redirect = 1'b0;
    #1;
    chk("rd1_valids",  32'({fd_valid, x_valid, mw_valid}), 32'(3'b001));
    chk("rd1_inst_fd", inst_fd, NOP);
    chk("rd1_inst",    inst_cnt, 32'd3);
    tick(); // c7
    chk("rd2_pc_fd",   pc_fd, 32'h4000_0100);
    chk("rd2_fd_vld",  32'(fd_valid), 32'(1'b1));
    chk("rd2_inst_fd", inst_fd, 32'h4000_0100 ^ K);
    repeat (3) tick(); // c10
    chk("rd_cycle",    cycle_cnt, 32'd9);
    chk("rd_inst",     inst_cnt, 32'd5);   // straight-line would be 7

    // Straight-line fetch, 10 cycles
    exp_pc = 32'h4000_010C; exp_cyc = 32'd9; exp_inst = 32'd5;
    chk("sl_pc_start", pc_fd, exp_pc);
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_pc += 32'd4; exp_cyc += 32'd1; exp_inst += 32'd1;
      chk("sl_pc_fd",   pc_fd, exp_pc);
      chk("sl_inst_fd", inst_fd, exp_pc ^ K);
      chk("sl_inst",    inst_cnt, exp_inst);
    end
    chk("sl_cycle", cycle_cnt, 32'd19);

    // Stall for 3 cycles with redirect held throughout
    stall_req = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_0200;
    #1;
    chk("st_pipe_en",  32'(pipe_en), 32'(1'b0));
    chk("st_pc_fetch", pc_fetch, 32'h4000_0134);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_state",    32'(state), 32'(2'b10));
      chk("st_pc_fd",    pc_fd, 32'h4000_0134);
      chk("st_pc_fetch", pc_fetch, 32'h4000_0134);
      chk("st_valids",   32'({fd_valid, x_valid, mw_valid}), 32'(3'b111));
      chk("st_inst",     inst_cnt, 32'd15);
    end
    chk("st_cycle", cycle_cnt, 32'd22);
    stall_req = 1'b0;
    #1 chk("st_rel_pc_fetch", pc_fetch, 32'h4000_0200);
    tick(); // c24
    redirect = 1'b0;
    #1;
    chk("st_rd_pc_fd",  pc_fd, 32'h4000_0200);
    chk("st_rd_valids", 32'({fd_valid, x_valid, mw_valid}), 32'(3'b001));
    chk("st_rd_state",  32'(state), 32'(2'b01));
    chk("st_rd_inst",   inst_cnt, 32'd16);
    tick(); // c25
    chk("st_rd2_fd",    inst_fd, 32'h4000_0200 ^ K);

    // Counter clear at cycle_cnt = 57
    repeat (33) tick(); // c58
    chk("cc_cycle_pre", cycle_cnt, 32'd57);
    chk("cc_inst_pre",  inst_cnt, 32'd48);
    chk("cc_mw",        32'(mw_valid), 32'(1'b1));
    chk("cc_pc_fd",     pc_fd, 32'h4000_0284);
    counter_rst = 1'b1;
    tick(); // c59
    counter_rst = 1'b0;
    chk("cc_cycle_clr", cycle_cnt, 32'd0);
    chk("cc_inst_clr",  inst_cnt, 32'd0);
    tick(); // c60
    chk("cc_cycle_run", cycle_cnt, 32'd1);
    chk("cc_inst_run",  inst_cnt, 32'd1);

    // Cycle counter wrap
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt;
    #1 chk("wr_pre", cycle_cnt, 32'hFFFF_FFFF);
    tick(); // c61
    chk("wr_post", cycle_cnt, 32'd0);
    chk("wr_inst", inst_cnt, 32'd2);

    // Asynchronous reset in the middle of a stall
    stall_req = 1'b1;
    tick();
    chk("ar_state_pre", 32'(state), 32'(2'b10));
    #2 rst = 1'b1;
    #1;
    chk("ar_valids",   32'({fd_valid, x_valid, mw_valid}), 32'(3'b000));
    chk("ar_pc_fetch", pc_fetch, RPC);
    chk("ar_pc_fd",    pc_fd, RPC);
    chk("ar_state",    32'(state), 32'(2'b00));
    chk("ar_pipe_en",  32'(pipe_en), 32'(1'b0));
    chk("ar_inst_fd",  inst_fd, NOP);
    chk("ar_cnts",     cycle_cnt | inst_cnt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
